// File: rtl/sha256_round_engine.sv
// SHA-256 compression core: one round per accepted schedule word, then
// chaining-value feedforward and a held digest with valid/ready handshake.
module sha256_round_engine #(
    parameter int NUM_ROUNDS = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [255:0] h_in,
    input  logic         w_valid,
    input  logic [31:0]  w_data,
    output logic         w_ready,
    output logic         digest_valid,
    output logic [255:0] digest,
    input  logic         digest_ready,
    output logic         busy
);

    localparam int CW = $clog2(NUM_ROUNDS);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

    localparam logic [31:0] K [NUM_ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // Working variables packed so that index 7 is 'a', matching the h_in word order.
    logic [7:0][31:0]   wv_q, wv_d;
    logic [7:0][31:0]   hc_q, hc_d;
    logic [255:0]       digest_q, digest_d;
    logic               dvalid_q, dvalid_d;

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] s0, s1, ch, maj, t1, t2;
    logic        accept, last;

    assign {a, b, c, d, e, f, g, h} = wv_q;

    assign s1  = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
    assign ch  = (e & f) ^ (~e & g);
    assign t1  = h + s1 + ch + K[cnt_q] + w_data;
    assign s0  = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
    assign maj = (a & b) ^ (a & c) ^ (b & c);
    assign t2  = s0 + maj;

    assign accept = w_valid && w_ready;
    assign last   = (cnt_q == CW'(NUM_ROUNDS - 1));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ROUND;
            ROUND:   if (accept && last) state_d = FINAL;
            FINAL:   state_d = DONE;
            DONE:    if (digest_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        w_ready = (state_q == ROUND);
        busy    = (state_q != IDLE);
    end

    always_comb begin
        cnt_d    = cnt_q;
        wv_d     = wv_q;
        hc_d     = hc_q;
        digest_d = digest_q;
        dvalid_d = dvalid_q;
        case (state_q)
            IDLE: if (start) begin
                hc_d  = h_in;
                wv_d  = h_in;
                cnt_d = '0;
            end
            ROUND: if (accept) begin
                wv_d  = {t1 + t2, a, b, c, d + t1, e, f, g};
                cnt_d = cnt_q + 1'b1;
            end
            FINAL: begin
                for (int i = 0; i < 8; i++) digest_d[i*32 +: 32] = wv_q[i] + hc_q[i];
                dvalid_d = 1'b1;
            end
            DONE: if (digest_ready) dvalid_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            wv_q     <= '0;
            hc_q     <= '0;
            digest_q <= '0;
            dvalid_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wv_q     <= wv_d;
            hc_q     <= hc_d;
            digest_q <= digest_d;
            dvalid_q <= dvalid_d;
        end
    end

    assign digest       = digest_q;
    assign digest_valid = dvalid_q;

endmodule

// File: tb/tb_sha256_round_engine.sv
// Bench for sha256_round_engine: directed SHA-256 vectors plus random blocks
// checked against an array-based compression model.
module tb_sha256_round_engine;

    typedef logic [63:0][31:0] wsched_t;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_DIG =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMPTY_DIG =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] TWO_DIG =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    logic         clk = 1'b0, reset_n = 1'b0, start = 1'b0, w_valid = 1'b0, digest_ready = 1'b1;
    logic [255:0] h_in = '0;
    logic [31:0]  w_data = '0;
    logic         w_ready, digest_valid, busy;
    logic [255:0] digest;

    int checks = 0, failures = 0;
    int hs_cnt = 0;

    sha256_round_engine dut (
        .clk(clk), .reset_n(reset_n), .start(start), .h_in(h_in),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .digest_valid(digest_valid), .digest(digest),
        .digest_ready(digest_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (w_valid && w_ready) hs_cnt <= hs_cnt + 1;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic wsched_t expand(input logic [511:0] blk);
        logic [31:0] w [64];
        wsched_t r;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int t = 0; t < 64; t++) r[t] = w[t];
        return r;
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hv, input wsched_t w);
        logic [31:0] v [8];
        logic [31:0] hh [8];
        logic [31:0] x1, x2;
        logic [255:0] r;
        for (int j = 0; j < 8; j++) begin hh[j] = hv[255 - 32*j -: 32]; v[j] = hh[j]; end
        for (int t = 0; t < 64; t++) begin
            x1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            x2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + x1;
            v[0] = x1 + x2;
        end
        for (int j = 0; j < 8; j++) r[255 - 32*j -: 32] = v[j] + hh[j];
        return r;
    endfunction

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [255:0] hv);
        h_in  = hv;
        start = 1'b1;
        step();
        start = 1'b0;
        h_in  = ~hv;
        chk("start_to_wready", w_ready, 1);
    endtask

    task automatic feed(input wsched_t w, input int maxgap, input int start_at,
                        input int abort_at, output bit aborted);
        int tmo;
        aborted = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (maxgap > 0) repeat ($urandom_range(maxgap, 0)) begin w_valid = 1'b0; step(); end
            w_valid = 1'b1;
            w_data  = w[i];
            if (i == start_at) begin start = 1'b1; h_in = '1; end
            if (i == abort_at) begin
                #2 reset_n = 1'b0;
                #1;
                chk("rst_mid_digest", digest, 0);
                chk("rst_mid_dvalid", digest_valid, 0);
                chk("rst_mid_wready", w_ready, 0);
                chk("rst_mid_busy", busy, 0);
                w_valid = 1'b0;
                aborted = 1'b1;
                return;
            end
            tmo = 0;
            while (!w_ready && tmo < 20) begin step(); tmo++; end
            if (!w_ready) chk("wready_wait", w_ready, 1);
            step();
            start = 1'b0;
        end
        w_valid = 1'b0;
    endtask

    task automatic wait_dv();
        int tmo = 0;
        while (!digest_valid && tmo < 20) begin step(); tmo++; end
        chk("dvalid_wait", digest_valid, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        wsched_t w_abc, w_empty, w_b1, w_b2, w_rnd;
        logic [255:0] d0, hr;
        logic [511:0] blk;
        bit ab;
        int hs0;

        w_abc   = expand({32'h61626380, 448'h0, 32'h00000018});
        w_empty = expand({32'h80000000, 480'h0});
        w_b1    = expand({32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000});
        w_b2    = expand({480'h0, 32'h000001c0});

        // Reset state
        #1;
        chk("rst_digest", digest, 0);
        chk("rst_dvalid", digest_valid, 0);
        chk("rst_wready", w_ready, 0);
        chk("rst_busy", busy, 0);
        step(); step();
        reset_n = 1'b1;
        step();

        // Words offered in IDLE are not consumed
        hs0 = hs_cnt;
        w_valid = 1'b1; w_data = 32'hdeadbeef;
        repeat (3) step();
        w_valid = 1'b0;
        chk("idle_no_consume", 256'(hs_cnt - hs0), 0);
        chk("idle_busy", busy, 0);

        // "abc", back-to-back; digest_valid exactly 2 cycles after last handshake
        chk("model_abc", compress(IV, w_abc), ABC_DIG);
        hs0 = hs_cnt;
        do_start(IV);
        feed(w_abc, 0, -1, -1, ab);
        chk("abc_words", 256'(hs_cnt - hs0), 64);
        chk("abc_final_dvalid", digest_valid, 0);
        chk("abc_final_busy", busy, 1);
        step();
        chk("abc_dvalid_2cyc", digest_valid, 1);
        chk("abc_digest", digest, ABC_DIG);
        step();
        chk("abc_idle_busy", busy, 0);
        chk("abc_idle_dvalid", digest_valid, 0);
        chk("abc_digest_held", digest, ABC_DIG);

        // Empty message with random gaps and output backpressure
        digest_ready = 1'b0;
        hs0 = hs_cnt;
        do_start(IV);
        feed(w_empty, 5, -1, -1, ab);
        wait_dv();
        chk("empty_words", 256'(hs_cnt - hs0), 64);
        chk("empty_digest", digest, EMPTY_DIG);
        chk("empty_model", digest, compress(IV, w_empty));
        d0 = digest;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_digest_stable", digest, d0);
            chk("bp_dvalid", digest_valid, 1);
            chk("bp_busy", busy, 1);
            chk("bp_wready", w_ready, 0);
        end
        digest_ready = 1'b1;
        step();
        chk("bp_release_idle", busy, 0);
        chk("bp_release_dvalid", digest_valid, 0);

        // Start pulse mid-block is ignored; start at DONE handshake is ignored
        do_start(IV);
        feed(w_abc, 0, 20, -1, ab);
        wait_dv();
        chk("ign_start_digest", digest, ABC_DIG);
        start = 1'b1; h_in = '1;
        step();
        start = 1'b0;
        chk("start_at_done_idle", busy, 0);
        step();
        chk("start_at_done_still_idle", busy, 0);

        // Asynchronous reset at round 37, then a fresh "abc" block
        do_start(IV);
        feed(w_abc, 0, -1, 37, ab);
        chk("abort_taken", ab, 1);
        step();
        reset_n = 1'b1;
        step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_dvalid", digest_valid, 0);
        do_start(IV);
        feed(w_abc, 2, -1, -1, ab);
        wait_dv();
        chk("post_rst_abc", digest, ABC_DIG);
        step();

        // Two-block chained message
        do_start(IV);
        feed(w_b1, 3, -1, -1, ab);
        wait_dv();
        d0 = digest;
        chk("chain_blk1_model", d0, compress(IV, w_b1));
        step();
        do_start(d0);
        feed(w_b2, 1, -1, -1, ab);
        wait_dv();
        chk("chain_digest", digest, TWO_DIG);
        step();

        // Random chaining values and message blocks
        for (int n = 0; n < 4; n++) begin
            for (int j = 0; j < 8; j++) hr[j*32 +: 32] = $urandom;
            for (int j = 0; j < 16; j++) blk[j*32 +: 32] = $urandom;
            w_rnd = expand(blk);
            hs0 = hs_cnt;
            do_start(hr);
            feed(w_rnd, n, -1, -1, ab);
            wait_dv();
            chk("rand_words", 256'(hs_cnt - hs0), 64);
            chk("rand_digest", digest, compress(hr, w_rnd));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sha256_round_engine.md
Name: sha256_round_engine

Overview:
- Consumer of the expanded message schedule. Takes one 32-bit schedule word W[t] per handshake and performs one SHA-256 compression round per accepted word.
- Holds the working variables a..h and a 6-bit round counter, and contains the 64-entry K constant ROM.
- After round 63 it adds the chaining value (feedforward) and presents a 256-bit digest with a valid/ready handshake.
- Sits between the message-schedule generator and the nonce/hash control logic of the mining datapath.

Parameters:
- NUM_ROUNDS, 64, rounds per block; fixed by SHA-256 and must not be overridden. It sizes the round counter and the ROM.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; loads h_in, accepted only in IDLE
- h_in  input  256  chaining value H0..H7, H0 in bits [255:224]
- w_valid  input  1  schedule word valid
- w_data  input  32  schedule word W[t]
- w_ready  output  1  engine accepts w_data this cycle
- digest_valid  output  1  digest available
- digest  output  256  H0'..H7', H0' in bits [255:224]
- digest_ready  input  1  downstream accepts digest
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, round counter=0, a..h=0, stored chaining value=0.
  - digest=0, digest_valid=0, w_ready=0, busy=0.
  - Reset mid-block abandons the block with no partial digest.
- Arithmetic:
  - All arithmetic is mod 2^32.
  - S1=ROTR6(e)^ROTR11(e)^ROTR25(e); ch=(e&f)^(~e&g).
  - T1=h+S1+ch+K[t]+W[t].
  - S0=ROTR2(a)^ROTR13(a)^ROTR22(a); maj=(a&b)^(a&c)^(b&c).
  - T2=S0+maj.
  - Update: h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2.
  - K is the standard SHA-256 table: K[0]=0x428a2f98 … K[63]=0xc67178f2.
- States:
  - IDLE:
    - w_ready=0.
    - start=1: latch h_in into the chaining register and into a..h, counter=0, go to ROUND.
  - ROUND:
    - w_ready=1.
    - On w_valid&w_ready: one round using K[counter] and w_data, counter increments.
    - Accepting the word at counter=63: go to FINAL, counter wraps to 0.
    - No w_valid: state is held; stalls of any length are legal.
  - FINAL:
    - One cycle, w_ready=0.
    - digest<={a+H0,…,h+H7}; digest_valid<=1; go to DONE.
  - DONE:
    - digest_valid=1 and digest held stable until digest_ready=1.
    - On digest_valid&digest_ready: digest_valid<=0, go to IDLE; digest keeps its last value.
- Latency: start to first w_ready is 1 cycle. Last word accepted to digest_valid is 2 cycles (FINAL, then registered valid).
- Throughput: 64 words in 64 consecutive cycles when w_valid is held high. One block per 67 cycles minimum, with digest_ready tied high.
- Boundary conditions:
  - start outside IDLE is ignored; the block in flight is not disturbed.
  - start in the same cycle as the DONE handshake is ignored; the next start must come in IDLE.
  - w_valid in IDLE/FINAL/DONE: the word is not consumed (w_ready=0).
  - h_in is sampled only on an accepted start; later changes have no effect.

Test Plan:
- "abc": start with the standard IV (0x6a09e667 0xbb67ae85 0x3c6ef372 0xa54ff53a 0x510e527f 0x9b05688c 0x1f83d9ab 0x5be0cd19). Feed W[0..63] from the model (W0=0x61626380, W15=0x00000018), back-to-back. → digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, and digest_valid rises exactly 2 cycles after the 64th handshake.
- Empty message: IV; W0=0x80000000, W1..W15=0, expanded. Insert random w_valid gaps of 0-5 cycles. → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855, and exactly 64 words are consumed.
- Output backpressure: hold digest_ready=0 for 10 cycles after digest_valid. → digest is stable, busy=1, w_ready=0 throughout; on release, IDLE is reached the next cycle.
- Ignored start: pulse start with h_in=all-ones during round 20 of the "abc" block. → digest is unchanged from the "abc" result.
- Reset mid-operation: assert reset_n=0 asynchronously at round 37. → all outputs 0 immediately. A fresh "abc" block afterwards gives the correct digest.
- Chained blocks: two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq". Feed the first digest as h_in of the second block. → 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
